axi_slave_demux_w: RTL

Write-path router between the single AXI master port and slaves s0, s1 and s3 of the interconnect; the write-side counterpart of the read-data mux. It accepts one write address from the master, decodes it to one slave, and forwards the AW beat and exactly awlen+1 W beats to that slave. It then routes the slave's B response back to the master. Unmapped addresses are absorbed internally and answered with DECERR. One transaction is in flight at a time.

---
 rtl/axi_slave_demux_w.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_demux_w.sv
// AXI write router: one master port to slaves s0/s1/s3; unmapped addresses answered with DECERR.
// Latency: AW forwarded one cycle after accept; W and B are combinational pass-through.
// Backpressure: one transaction in flight; awready stays low until the cycle after the B handshake.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_slave_demux_w #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] REGION_MASK = 32'hF000_0000,
   parameter logic [ADDR_W-1:0] S0_BASE     = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] S1_BASE     = 32'h1000_0000,
   parameter logic [ADDR_W-1:0] S3_BASE     = 32'h3000_0000
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   // master side
   input  logic [7:0]                awid,
   input  logic [ADDR_W-1:0]         awaddr,
   input  logic [7:0]                awlen,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [`DATA_WIDTH-1:0]    wdata,
   input  logic [`DATA_WIDTH/8-1:0]  wstrb,
   input  logic                      wlast,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [7:0]                bid,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   // slave 0
   output logic [7:0]                s0_AWID,
   output logic [ADDR_W-1:0]         s0_AWADDR,
   output logic [7:0]                s0_AWLEN,
   output logic                      s0_AWVALID,
   input  logic                      s0_AWREADY,
   output logic [`DATA_WIDTH-1:0]    s0_WDATA,
   output logic [`DATA_WIDTH/8-1:0]  s0_WSTRB,
   output logic                      s0_WLAST,
   output logic                      s0_WVALID,
   input  logic                      s0_WREADY,
   input  logic [7:0]                s0_BID,
   input  logic [1:0]                s0_BRESP,
   input  logic                      s0_BVALID,
   output logic                      s0_BREADY,
   // slave 1
   output logic [7:0]                s1_AWID,
   output logic [ADDR_W-1:0]         s1_AWADDR,
   output logic [7:0]                s1_AWLEN,
   output logic                      s1_AWVALID,
   input  logic                      s1_AWREADY,
   output logic [`DATA_WIDTH-1:0]    s1_WDATA,
   output logic [`DATA_WIDTH/8-1:0]  s1_WSTRB,
   output logic                      s1_WLAST,
   output logic                      s1_WVALID,
   input  logic                      s1_WREADY,
   input  logic [7:0]                s1_BID,
   input  logic [1:0]                s1_BRESP,
   input  logic                      s1_BVALID,
   output logic                      s1_BREADY,
   // slave 3
   output logic [7:0]                s3_AWID,
   output logic [ADDR_W-1:0]         s3_AWADDR,
   output logic [7:0]                s3_AWLEN,
   output logic                      s3_AWVALID,
   input  logic                      s3_AWREADY,
   output logic [`DATA_WIDTH-1:0]    s3_WDATA,
   output logic [`DATA_WIDTH/8-1:0]  s3_WSTRB,
   output logic                      s3_WLAST,
   output logic                      s3_WVALID,
   input  logic                      s3_WREADY,
   input  logic [7:0]                s3_BID,
   input  logic [1:0]                s3_BRESP,
   input  logic                      s3_BVALID,
   output logic                      s3_BREADY
);

   typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_W_ERR, ST_B_ERR} state_t;

   localparam logic [1:0] SEL_S0 = 2'd0;
   localparam logic [1:0] SEL_S1 = 2'd1;
   localparam logic [1:0] SEL_S3 = 2'd3;

   state_t              state_q, state_d;
   logic [1:0]          sel_q, sel_d;
   logic [7:0]          id_q, id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          cnt_q, cnt_d;

   logic                awready_c;
   logic                aw_vld, w_vld, b_rdy;
   logic                sel_awready, sel_wready, sel_bvalid;
   logic [7:0]          sel_bid;
   logic [1:0]          sel_bresp;
   logic                last_beat;

   // Master wlast is deliberately ignored; beat count comes from the latched awlen.
   logic unused_wlast;
   assign unused_wlast = wlast;

   assign last_beat = (cnt_q == len_q);

   always_comb begin
      sel_awready = s3_AWREADY;
      sel_wready  = s3_WREADY;
      sel_bvalid  = s3_BVALID;
      sel_bid     = s3_BID;
      sel_bresp   = s3_BRESP;
      case (sel_q)
         SEL_S0: begin
            sel_awready = s0_AWREADY;
            sel_wready  = s0_WREADY;
            sel_bvalid  = s0_BVALID;
            sel_bid     = s0_BID;
            sel_bresp   = s0_BRESP;
         end
         SEL_S1: begin
            sel_awready = s1_AWREADY;
            sel_wready  = s1_WREADY;
            sel_bvalid  = s1_BVALID;
            sel_bid     = s1_BID;
            sel_bresp   = s1_BRESP;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      awready_c = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      bid       = 8'd0;
      bresp     = 2'b00;
      aw_vld    = 1'b0;
      w_vld     = 1'b0;
      b_rdy     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            awready_c = 1'b1;
            if (awvalid) begin
               id_d   = awid;
               addr_d = awaddr;
               len_d  = awlen;
               cnt_d  = 8'd0;
               if ((awaddr & REGION_MASK) == S0_BASE) begin
                  sel_d   = SEL_S0;
                  state_d = ST_AW;
               end else if ((awaddr & REGION_MASK) == S1_BASE) begin
                  sel_d   = SEL_S1;
                  state_d = ST_AW;
               end else if ((awaddr & REGION_MASK) == S3_BASE) begin
                  sel_d   = SEL_S3;
                  state_d = ST_AW;
               end else begin
                  state_d = ST_W_ERR;
               end
            end
         end
         ST_AW: begin
            aw_vld = 1'b1;
            if (sel_awready) state_d = ST_W;
         end
         ST_W: begin
            w_vld  = wvalid;
            wready = sel_wready;
            if (wvalid && sel_wready) begin
               cnt_d = cnt_q + 8'd1;
               if (last_beat) state_d = ST_B;
            end
         end
         ST_B: begin
            bvalid = sel_bvalid;
            bid    = sel_bid;
            bresp  = sel_bresp;
            b_rdy  = bready;
            if (sel_bvalid && bready) state_d = ST_IDLE;
         end
         ST_W_ERR: begin
            wready = 1'b1;
            if (wvalid) begin
               cnt_d = cnt_q + 8'd1;
               if (last_beat) state_d = ST_B_ERR;
            end
         end
         ST_B_ERR: begin
            bvalid = 1'b1;
            bid    = id_q;
            bresp  = 2'b11;
            if (bready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_S0;
         id_q    <= 8'd0;
         addr_q  <= '0;
         len_q   <= 8'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   // IDLE is the reset state, so only awready needs gating to stay low during reset.
   assign awready = awready_c & rst_ni;

   assign s0_AWID    = id_q;
   assign s0_AWADDR  = addr_q;
   assign s0_AWLEN   = len_q;
   assign s0_AWVALID = aw_vld && (sel_q == SEL_S0);
   assign s0_WDATA   = wdata;
   assign s0_WSTRB   = wstrb;
   assign s0_WLAST   = last_beat;
   assign s0_WVALID  = w_vld && (sel_q == SEL_S0);
   assign s0_BREADY  = b_rdy && (sel_q == SEL_S0);

   assign s1_AWID    = id_q;
   assign s1_AWADDR  = addr_q;
   assign s1_AWLEN   = len_q;
   assign s1_AWVALID = aw_vld && (sel_q == SEL_S1);
   assign s1_WDATA   = wdata;
   assign s1_WSTRB   = wstrb;
   assign s1_WLAST   = last_beat;
   assign s1_WVALID  = w_vld && (sel_q == SEL_S1);
   assign s1_BREADY  = b_rdy && (sel_q == SEL_S1);

   assign s3_AWID    = id_q;
   assign s3_AWADDR  = addr_q;
   assign s3_AWLEN   = len_q;
   assign s3_AWVALID = aw_vld && (sel_q == SEL_S3);
   assign s3_WDATA   = wdata;
   assign s3_WSTRB   = wstrb;
   assign s3_WLAST   = last_beat;
   assign s3_WVALID  = w_vld && (sel_q == SEL_S3);
   assign s3_BREADY  = b_rdy && (sel_q == SEL_S3);

endmodule
